// File: rtl/music_box_state_scheduler.sv
// Music box mode scheduler: round-robin arbitration of UI mode requests onto the
// shared currentState bus, with watchdog and a guard interval in DoNothing.
//
// state  | meaning
// IDLE   | currentState=0, waiting for any pending or new request
// ACTIVE | a mode owns the bus; ends on cancel, completion or watchdog
// GUARD  | currentState=0 held for GUARD_TICKS ticks so mode modules reset
module music_box_state_scheduler #(
  parameter int TIMEOUT_TICKS = 10000,
  parameter int GUARD_TICKS   = 3
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic        tick_1khz,
  input  logic [4:0]  request,
  input  logic        cancel,
  input  logic [4:0]  stateComplete,
  output logic [4:0]  currentState,
  output logic        busy,
  output logic        timeoutFlag,
  output logic [31:0] debugString
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_TICKS - 1);
  localparam logic [15:0] GUARD_LAST   = 16'(GUARD_TICKS - 1);

  state_t      state;
  logic [4:1]  pending;
  logic [2:0]  last_grant;
  logic [15:0] tick_count;

  logic [4:1]  cand;
  logic [4:1]  grant_mask;
  logic [4:1]  cur_mask;
  logic [2:0]  grant;
  logic [2:0]  idx;
  logic        complete_hit;
  logic        watchdog_hit;
  logic        unused_req0;

  assign unused_req0 = request[0];

  // Round-robin search starting just after the last granted mode, wrapping 4 -> 1.
  always_comb begin
    cand       = pending | request[4:1];
    grant      = 3'd0;
    grant_mask = 4'b0000;
    idx        = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = 3'(((int'(last_grant) + k - 1) % 4) + 1);
      if (grant == 3'd0 && cand[idx]) begin
        grant           = idx;
        grant_mask[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    cur_mask = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      cur_mask[i] = (currentState == 5'(i));
    end
  end

  assign complete_hit = stateComplete[currentState];
  assign watchdog_hit = tick_1khz && (tick_count == TIMEOUT_LAST);

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state        <= IDLE;
      currentState <= 5'd0;
      pending      <= 4'b0000;
      last_grant   <= 3'd4;
      tick_count   <= 16'd0;
      busy         <= 1'b0;
      timeoutFlag  <= 1'b0;
    end else begin
      timeoutFlag <= 1'b0;
      case (state)
        IDLE: begin
          pending <= cand & ~grant_mask;
          if (grant != 3'd0) begin
            state        <= ACTIVE;
            currentState <= {2'b00, grant};
            last_grant   <= grant;
            tick_count   <= 16'd0;
            busy         <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cancel || complete_hit || watchdog_hit) begin
            // A re-request of the ending mode on its exit cycle is kept.
            pending      <= pending | request[4:1];
            state        <= GUARD;
            currentState <= 5'd0;
            tick_count   <= 16'd0;
            timeoutFlag  <= !cancel && !complete_hit;
          end else begin
            pending <= pending | (request[4:1] & ~cur_mask);
            if (tick_1khz) begin
              tick_count <= tick_count + 16'd1;
            end
          end
        end
        GUARD: begin
          pending <= pending | request[4:1];
          if (tick_1khz) begin
            if (tick_count == GUARD_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              tick_count <= 16'd0;
            end else begin
              tick_count <= tick_count + 16'd1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          currentState <= 5'd0;
          busy         <= 1'b0;
          tick_count   <= 16'd0;
        end
      endcase
    end
  end

  assign debugString = {pending, last_grant, state, 7'd0, tick_count};

endmodule

// File: tb/tb_music_box_state_scheduler.sv
// Self-checking bench for music_box_state_scheduler: vector table plus hand-written
// watchdog, wrong-index completion and mid-mode reset sequences, checked via a scoreboard.
module tb_music_box_state_scheduler;

  logic        clock_50Mhz = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1khz = 1'b0;
  logic [4:0]  request = 5'd0;
  logic        cancel = 1'b0;
  logic [4:0]  stateComplete = 5'd0;
  logic [4:0]  currentState;
  logic        busy;
  logic        timeoutFlag;
  logic [31:0] debugString;

  always #10 clock_50Mhz = ~clock_50Mhz;

  music_box_state_scheduler #(.TIMEOUT_TICKS(5), .GUARD_TICKS(3)) dut (
    .clock_50Mhz   (clock_50Mhz),
    .reset         (reset),
    .tick_1khz     (tick_1khz),
    .request       (request),
    .cancel        (cancel),
    .stateComplete (stateComplete),
    .currentState  (currentState),
    .busy          (busy),
    .timeoutFlag   (timeoutFlag),
    .debugString   (debugString)
  );

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic       can;
    logic [4:0] comp;
    logic       tick;
    logic [4:0] e_state;
    logic       e_busy;
    logic       e_tf;
    logic [3:0] e_pend;
  } vec_t;

  typedef struct {
    logic [4:0] st;
    logic       busy;
    logic       tf;
    logic [3:0] pend;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rst, logic [4:0] req, logic can, logic [4:0] comp,
                              logic tick, logic [4:0] st, logic bz, logic tf, logic [3:0] pend);
    vec_t v;
    v.rst = rst; v.req = req; v.can = can; v.comp = comp; v.tick = tick;
    v.e_state = st; v.e_busy = bz; v.e_tf = tf; v.e_pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input vec_t v, input string tag);
    exp_t e;
    reset         = v.rst;
    request       = v.req;
    cancel        = v.can;
    stateComplete = v.comp;
    tick_1khz     = v.tick;
    e.st = v.e_state; e.busy = v.e_busy; e.tf = v.e_tf; e.pend = v.e_pend;
    sb.push_back(e);
    @(posedge clock_50Mhz);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " currentState"}, 32'(currentState), 32'(e.st));
      check({tag, " busy"}, 32'(busy), 32'(e.busy));
      check({tag, " timeoutFlag"}, 32'(timeoutFlag), 32'(e.tf));
      check({tag, " pending"}, 32'(debugString[31:28]), 32'(e.pend));
    end
  endtask

  // GUARD_TICKS=3: two ticks keep busy, third returns to IDLE.
  task automatic guard_out(input logic [3:0] pend, input string tag);
    cyc(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0, pend), tag);
    cyc(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0, pend), tag);
    cyc(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, pend), tag);
  endtask

  initial begin
    @(posedge clock_50Mhz);
    #1;

    // reset, basic request/completion, reset, round robin 1..4
    vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 5'b01000, 0, 5'd0, 0, 5'd3, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 5'd0, 0, 5'b01000, 0, 5'd0, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000));
    for (int g = 1; g <= 4; g++) begin
      logic [3:0] p;
      logic [4:0] onehot;
      p = 4'(4'b1110 << (g - 1));
      onehot = 5'(1 << g);
      vecs.push_back(mk(0, (g == 1) ? 5'b11110 : 5'd0, 0, 5'd0, 0, 5'(g), 1, 0, p));
      vecs.push_back(mk(0, 5'd0, 0, onehot, 0, 5'd0, 1, 0, p));
      vecs.push_back(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0, p));
      vecs.push_back(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 0, p));
      vecs.push_back(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, p));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i], $sformatf("vec%0d", i));
      if (i == 1) check("reset debugString", debugString, 32'h0800_0000);
    end

    // watchdog expiry after exactly 5 ticks
    cyc(mk(0, 5'b00100, 0, 5'd0, 0, 5'd2, 1, 0, 4'b0000), "wd grant");
    for (int t = 0; t < 4; t++) cyc(mk(0, 5'd0, 0, 5'd0, 1, 5'd2, 1, 0, 4'b0000), "wd run");
    check("wd tickCount", 32'(debugString[15:0]), 32'd4);
    check("wd fsm code", 32'(debugString[24:23]), 32'd1);
    cyc(mk(0, 5'd0, 0, 5'd0, 1, 5'd0, 1, 1, 4'b0000), "wd expire");
    cyc(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 4'b0000), "wd pulse end");
    check("wd guard code", 32'(debugString[24:23]), 32'd2);
    guard_out(4'b0000, "wd guard");

    // cancel coinciding with expiry suppresses timeoutFlag
    cyc(mk(0, 5'b00100, 0, 5'd0, 0, 5'd2, 1, 0, 4'b0000), "wdc grant");
    for (int t = 0; t < 4; t++) cyc(mk(0, 5'd0, 0, 5'd0, 1, 5'd2, 1, 0, 4'b0000), "wdc run");
    cyc(mk(0, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 4'b0000), "wdc cancel");
    guard_out(4'b0000, "wdc guard");

    // wrong-index completion ignored; request during GUARD granted after exit
    cyc(mk(0, 5'b01000, 0, 5'd0, 0, 5'd3, 1, 0, 4'b0000), "wi grant");
    cyc(mk(0, 5'd0, 0, 5'b00100, 0, 5'd3, 1, 0, 4'b0000), "wi wrong comp");
    cyc(mk(0, 5'd0, 0, 5'b01000, 0, 5'd0, 1, 0, 4'b0000), "wi comp");
    cyc(mk(0, 5'b00010, 0, 5'd0, 0, 5'd0, 1, 0, 4'b0001), "wi guard req");
    guard_out(4'b0001, "wi guard");
    cyc(mk(0, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 4'b0000), "wi regrant");

    // reach state 4 with pending 0011, then reset mid-mode
    cyc(mk(0, 5'b10000, 0, 5'd0, 0, 5'd1, 1, 0, 4'b1000), "rm pend4");
    cyc(mk(0, 5'd0, 0, 5'b00010, 0, 5'd0, 1, 0, 4'b1000), "rm comp1");
    guard_out(4'b1000, "rm guard");
    cyc(mk(0, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 4'b0000), "rm grant4");
    cyc(mk(0, 5'b10110, 0, 5'd0, 0, 5'd4, 1, 0, 4'b0011), "rm drop own");
    cyc(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000), "rm reset");
    check("rm debugString", debugString, 32'h0800_0000);

    reset = 1'b0;
    request = 5'd0;
    stateComplete = 5'd0;
    cancel = 1'b0;
    tick_1khz = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_box_state_scheduler.md
# music_box_state_scheduler

Top-level sequencer for the music box user interface. Collects mode requests from the button/UI logic, arbitrates them round-robin, and drives the shared `currentState` bus that every MusicBoxState_* mode module decodes. Returns the bus to DoNothing (0) when the active mode reports completion, is cancelled or times out. Between modes it holds a guard interval long enough for the 1 kHz-clocked mode modules to observe state 0 and clear their internal counters.

## Interface
- `TIMEOUT_TICKS`, default 10000: watchdog limit in `tick_1khz` pulses. Legal range 1..65535.
- `GUARD_TICKS`, default 3: number of `tick_1khz` pulses that state 0 is held after leaving a mode. Legal range 2..255.
- `clock_50Mhz` in 1: sole clock. Everything is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tick_1khz` in 1: one-cycle enable pulse at 1 kHz, synchronous to `clock_50Mhz`.
- `request` in 5: mode request pulses or levels. Bit i requests state i. Bit 0 is ignored.
- `cancel` in 1: aborts the active mode.
- `stateComplete` in 5: completion flags from the mode modules. Bit i belongs to state i.
- `currentState` out 5: mode bus. 0 = DoNothing, 1 = MakeRecording, 2 = PlaySong0, 3 = PlayRecording, 4 = PlaySong1. Values 5..31 are never driven.
- `busy` out 1: high whenever the FSM is not IDLE.
- `timeoutFlag` out 1: one-cycle pulse when the watchdog ends a mode.
- `debugString` out 32: status word.
  - [31:28] pending[4:1]
  - [27:25] lastGrant
  - [24:23] FSM code (IDLE=0, ACTIVE=1, GUARD=2)
  - [22:16] zero
  - [15:0] tick counter

## Operation
- **Registers**
  - FSM {IDLE, ACTIVE, GUARD}.
  - `pending[4:1]`.
  - `lastGrant` (3 bits, values 1..4).
  - `tickCount` (16 bits).
- **Reset values:** FSM=IDLE, `currentState`=0, `pending`=0, `lastGrant`=4, `tickCount`=0, `busy`=0, `timeoutFlag`=0.
- **Request capture**
  - Every cycle: `pending` ← `pending` | `request[4:1]`.
  - Exception: in ACTIVE, the request bit equal to `currentState` is dropped and never pended.
  - A pending bit clears only on the cycle its request is granted.
- **IDLE**
  - Let `cand` = `pending` | `request[4:1]`.
  - If `cand` ≠ 0: grant the first set bit searching `lastGrant`+1, `lastGrant`+2, … with wrap 4→1.
  - On grant: `currentState` ← grant, `lastGrant` ← grant, clear that `pending` bit, `tickCount` ← 0, go to ACTIVE.
- **ACTIVE**, evaluated in priority order:
  1. `cancel` = 1 → go to GUARD.
  2. `stateComplete[currentState]` = 1 → go to GUARD.
  3. `tick_1khz` = 1 and `tickCount` = `TIMEOUT_TICKS`−1 → go to GUARD and pulse `timeoutFlag`.
  4. Otherwise `tickCount` increments on each `tick_1khz`.
  - Every transition to GUARD sets `currentState` ← 0 and `tickCount` ← 0.
  - `stateComplete` bits other than `currentState` are ignored.
- **GUARD**
  - `currentState` = 0.
  - `tickCount` increments on `tick_1khz`.
  - On the tick where `tickCount` = `GUARD_TICKS`−1: go to IDLE and set `tickCount` ← 0.
  - `cancel` and `stateComplete` are ignored. Requests keep pending.
- **`timeoutFlag`** is asserted only for the timeout cause. It is never asserted when `cancel` or `stateComplete` coincides with expiry.
- **Reset mid-mode:** everything returns to its reset value on the next edge. `currentState` goes to 0 immediately, with no guard interval.

## Timing
- **Request to `currentState` valid:** 1 cycle from IDLE. A request asserted at edge N makes `currentState` change at edge N+1.
- **Completion/cancel to `currentState`=0:** 1 cycle.
- **Minimum time in state 0 between modes:** `GUARD_TICKS`−1 full tick periods plus partial, so at least ≈2 ms at default. This guarantees at least one 1 kHz edge sees state 0.
- **Timeout:** mode lasts exactly `TIMEOUT_TICKS` tick pulses after entry.
- **Outputs:** all outputs are registered. No combinational path from input to output.
- **Simultaneous events:**
  - `request` and the grant of the same bit in the same cycle: the grant wins and the bit stays clear.
  - Request arriving on the exit cycle from ACTIVE: pended.

## Test plan
- **Reset values:** apply `reset` 2 cycles → `currentState`=0, `busy`=0, `debugString`=0x08000000 (`lastGrant`=4).
- **Basic request and completion:** `request`=5'b01000 for one cycle → `currentState`=3 next cycle. Pulse `stateComplete`=5'b01000 → `currentState`=0 next cycle. After 3 ticks, `busy`=0.
- **Round-robin:** `request`=5'b11110 held 1 cycle.
  - Grant order is 1, 2, 3, 4, each completed via `stateComplete`.
  - Pending bits clear one per grant.
- **Watchdog:** `TIMEOUT_TICKS`=5, request 2, no completion → `timeoutFlag` pulses on the 5th tick and `currentState`=0. Repeat with `cancel` on the same cycle → no `timeoutFlag`.
- **Wrong-index completion:** in state 3, `stateComplete`=5'b00100 → state stays 3. During GUARD, `request`=5'b00010 → state 1 granted exactly on GUARD exit.
- **Reset mid-mode:** `reset` asserted while in state 4 with `pending`=4'b0011 → next edge all registers at reset values and `pending`=0.
